// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the FIFO read port and sends each as an 8N1 UART frame (optional parity bit).
// Latency: pop strobe one cycle after the IDLE decision edge; tx falls two edges after that decision.
// Backpressure: a new frame starts only when enable=1 and the FIFO is non-empty; a frame in progress always completes.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic [7:0] sent_count
);

  // Baud counter width; a 1-bit floor keeps the declaration legal at the low end of the range.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic          USE_PAR   = (PARITY != 0);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q;
  logic          rd_q;
  logic          busy_q;
  logic [7:0]    sent_q;

  logic          baud_done;
  logic          par_d;

  // End of the current bit time, and the parity of the byte the FIFO is presenting.
  assign baud_done = (baud_q == BAUD_LAST);
  assign par_d     = (^fifo_data) ^ ODD_PAR;

  assign fifo_rd    = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign sent_count = sent_q;

  // Frame sequencer: every output is registered alongside the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= 8'h00;
    end else begin
      // The pop strobe lives for exactly the FETCH cycle.
      rd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          bit_q  <= 3'd0;
          if (enable && !fifo_empty) begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        // Pop already committed; the FIFO answers on the following cycle.
        S_FETCH: begin
          state_q <= S_LOAD;
        end

        S_LOAD: begin
          shift_q <= fifo_data;
          par_q   <= par_d;
          baud_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= S_START;
        end

        S_START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end

        // LSB first; tx is preloaded with the next bit so it changes on the shift edge.
        S_DATA: begin
          if (baud_done) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              if (USE_PAR) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end

        S_PARITY: begin
          if (baud_done) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end

        // Frame is counted on the same edge the sequencer returns to IDLE.
        S_STOP: begin
          if (baud_done) begin
            baud_q  <= '0;
            sent_q  <= sent_q + 8'd1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitters (no / even / odd parity) at 4 clocks per bit, each fed by a byte-queue FIFO model.
// Stimulus pushes bytes into the FIFO model and into an expected-frame queue; a line monitor decodes tx and pops/compares.
// Directed checks cover reset, pop timing, spacing, empty/disable, enable drop, mid-frame reset, parity and count wrap.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       emp    [3];
  logic [7:0] fdat   [3];
  logic       rd_w   [3];
  logic       tx_w   [3];
  logic       busy_w [3];
  logic [7:0] cnt_w  [3];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .PARITY      (g)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(emp[g]),
        .fifo_data (fdat[g]),
        .fifo_rd   (rd_w[g]),
        .tx        (tx_w[g]),
        .busy      (busy_w[g]),
        .sent_count(cnt_w[g])
      );
    end
  endgenerate

  int         total = 0;
  int         bad   = 0;
  logic [7:0] fq   [3][$];
  logic [7:0] expq [3][$];
  logic [7:0] nxt    [3];
  logic       rd_now [3];
  int         rdcnt  [3];
  int         rdlast [3];
  int         rdgap  [3];
  int         txlow  [3];
  int         cyc = 0;
  logic       last_par [3];

  // monitor state
  int          mcyc [3];
  logic        mact [3];
  logic [10:0] mfr  [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: observe outputs at negedge, serve pops, then apply FIFO read data just after posedge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nxt[d]    = fdat[d];
      rd_now[d] = rd_w[d];
      if (rd_w[d] === 1'b1) begin
        rdcnt[d]++;
        rdgap[d]  = cyc - rdlast[d];
        rdlast[d] = cyc;
        chk($sformatf("pop_nonempty%0d", d), (fq[d].size() > 0), 1);
        if (fq[d].size() > 0) nxt[d] = fq[d].pop_front();
      end
      if (tx_w[d] !== 1'b1) txlow[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      fdat[d] = nxt[d];
      emp[d]  = (fq[d].size() == 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input int d, input logic [7:0] b);
    fq[d].push_back(b);
    expq[d].push_back(b);
    emp[d] = 1'b0;
  endtask

  task automatic wait_rd(input int d);
    int n;
    n = 0;
    rd_now[d] = 1'b0;
    while (n < 20 && !rd_now[d]) begin
      tick();
      n++;
    end
    chk($sformatf("rd_timeout%0d", d), rd_now[d], 1);
  endtask

  task automatic check_frame(input int d, input int nb);
    logic [7:0] b;
    chk($sformatf("frame_expected%0d", d), (expq[d].size() > 0), 1);
    if (expq[d].size() > 0) begin
      b = expq[d].pop_front();
      chk($sformatf("start_bit%0d", d), mfr[d][0], 0);
      chk($sformatf("data%0d", d), mfr[d][8:1], b);
      if (nb == 11) begin
        last_par[d] = mfr[d][9];
        chk($sformatf("parity%0d", d), mfr[d][9], (^b) ^ (d == 2));
      end
      chk($sformatf("stop_bit%0d", d), mfr[d][nb-1], 1);
    end
  endtask

  // Line monitor: finds each start edge and samples every bit at mid bit time.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin : mon
      int nb;
      int idx;
      nb = (d == 0) ? 10 : 11;
      if (rst) begin
        mact[d] = 1'b0;
      end else if (!mact[d]) begin
        if (tx_w[d] === 1'b0) begin
          mact[d] = 1'b1;
          mcyc[d] = 0;
          mfr[d]  = '0;
        end
      end else begin
        mcyc[d]++;
        if (mcyc[d] % CPB == CPB / 2) begin
          idx = mcyc[d] / CPB;
          mfr[d][idx] = tx_w[d];
          if (idx == nb - 1) begin
            mact[d] = 1'b0;
            check_frame(d, nb);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int r0;
    int t0;
    for (int d = 0; d < 3; d++) begin
      emp[d] = 1'b1; fdat[d] = 8'h00; rdcnt[d] = 0; rdlast[d] = 0; rdgap[d] = 0;
      txlow[d] = 0; mact[d] = 1'b0; mcyc[d] = 0; last_par[d] = 1'b0; rd_now[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx_w[0], 1);
    chk("reset_busy", busy_w[0], 0);
    chk("reset_rd", rd_w[0], 0);
    chk("reset_count", cnt_w[0], 0);
    chk("reset_tx_par", tx_w[2], 1);
    rst = 1'b0;
    run(2);

    // Single byte 0xA5: tx high during LOAD, low from the following edge.
    enable = 1'b1;
    push(0, 8'hA5);
    wait_rd(0);
    chk("load_tx_high", tx_w[0], 1);
    tick();
    chk("start_tx_low", tx_w[0], 0);
    chk("start_busy", busy_w[0], 1);
    run(45);
    chk("single_count", cnt_w[0], 1);
    chk("single_rd_pulses", rdcnt[0], 1);
    chk("single_idle_busy", busy_w[0], 0);
    chk("single_idle_tx", tx_w[0], 1);

    // Back-to-back 0x00, 0xFF: pops 43 cycles apart.
    push(0, 8'h00);
    push(0, 8'hFF);
    run(100);
    chk("b2b_rd_pulses", rdcnt[0], 3);
    chk("b2b_rd_gap", rdgap[0], 43);
    chk("b2b_count", cnt_w[0], 3);

    // Empty FIFO with enable, then data with enable low.
    r0 = rdcnt[0];
    t0 = txlow[0];
    run(100);
    chk("empty_no_rd", rdcnt[0], r0);
    chk("empty_tx_high", txlow[0], t0);
    chk("empty_busy", busy_w[0], 0);
    enable = 1'b0;
    push(0, 8'h11);
    run(100);
    chk("disable_no_rd", rdcnt[0], r0);
    chk("disable_tx_high", txlow[0], t0);
    chk("disable_busy", busy_w[0], 0);
    enable = 1'b1;
    run(50);
    chk("reenable_rd", rdcnt[0], 4);
    chk("reenable_count", cnt_w[0], 4);

    // enable drops during DATA of 0x5A: frame finishes, 0x66 waits.
    push(0, 8'h5A);
    push(0, 8'h66);
    wait_rd(0);
    run(10);
    enable = 1'b0;
    run(60);
    chk("drop_rd_pulses", rdcnt[0], 5);
    chk("drop_count", cnt_w[0], 5);
    chk("drop_busy", busy_w[0], 0);
    enable = 1'b1;
    run(50);
    chk("resume_rd_pulses", rdcnt[0], 6);
    chk("resume_count", cnt_w[0], 6);

    // Reset during bit 3 of 0x3C: byte discarded, 0x81 follows.
    push(0, 8'h3C);
    push(0, 8'h81);
    wait_rd(0);
    run(19);
    rst = 1'b1;
    void'(expq[0].pop_front());
    tick();
    rst = 1'b0;
    chk("rst_tx", tx_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_count", cnt_w[0], 0);
    chk("rst_rd", rd_w[0], 0);
    run(50);
    chk("after_rst_rd_pulses", rdcnt[0], 8);
    chk("after_rst_count", cnt_w[0], 1);

    // Parity on 0x07: even -> 1, odd -> 0.
    push(1, 8'h07);
    push(2, 8'h07);
    run(60);
    chk("even_parity_bit", last_par[1], 1);
    chk("odd_parity_bit", last_par[2], 0);
    chk("even_count", cnt_w[1], 1);
    chk("odd_count", cnt_w[2], 1);

    // 255 more frames on top of the one already counted -> wraps to 0.
    for (int i = 0; i < 255; i++) push(0, 8'(i * 7 + 3));
    run(255 * 43 + 40);
    chk("wrap_count", cnt_w[0], 0);
    chk("wrap_rd_pulses", rdcnt[0], 263);
    chk("wrap_busy", busy_w[0], 0);

    for (int d = 0; d < 3; d++) chk($sformatf("exp_drained%0d", d), expq[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
